// File: rtl/ahb_s2m_mux_gen.sv
// AHB slave-to-master return mux with built-in default slave and a
// per-transfer wait-state watchdog that converts a hung slave into an ERROR.
module ahb_s2m_mux_gen #(
    parameter int N_SLAVES = 5,
    parameter int DATA_W   = 32,
    parameter int RESP_W   = 2,
    parameter int TIMEOUT  = 256,
    localparam int SEL_W   = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [N_SLAVES-1:0]          HSEL,
    input  logic [1:0]                   HTRANS,
    input  logic [N_SLAVES*DATA_W-1:0]   HRDATA_S,
    input  logic [N_SLAVES-1:0]          HREADY_S,
    input  logic [N_SLAVES*RESP_W-1:0]   HRESP_S,
    input  logic                         to_clr,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic [RESP_W-1:0]            HRESP,
    output logic                         to_flag,
    output logic [SEL_W-1:0]             to_slave
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]     WLIM  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
    localparam logic [CW-1:0]     WMAX  = {CW{1'b1}};
    localparam logic [RESP_W-1:0] R_OK  = {RESP_W{1'b0}};
    localparam logic [RESP_W-1:0] R_ERR = RESP_W'(1);

    typedef enum logic [1:0] {PASS = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2} state_e;

    state_e             state_q, state_d;
    logic               dsel_def_q, dsel_def_d;
    logic [SEL_W-1:0]   dsel_idx_q, dsel_idx_d;
    logic               dact_q, dact_d;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    logic               to_flag_q, to_flag_d;
    logic [SEL_W-1:0]   to_slave_q, to_slave_d;

    logic               a_def;
    logic [SEL_W-1:0]   a_idx;
    logic               s_rdy;
    logic [RESP_W-1:0]  s_resp;
    logic [DATA_W-1:0]  s_data;
    logic               rdy;
    logic [RESP_W-1:0]  resp;
    logic [DATA_W-1:0]  data;
    logic               to_ev;

    // Lowest set HSEL bit wins; scanning downward lets lower indices overwrite.
    always_comb begin
        a_def = 1'b1;
        a_idx = {SEL_W{1'b0}};
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            a_idx = HSEL[i] ? SEL_W'(i) : a_idx;
            a_def = a_def & ~HSEL[i];
        end
    end

    // Data-phase slave mux.
    always_comb begin
        s_rdy  = 1'b1;
        s_resp = R_OK;
        s_data = {DATA_W{1'b0}};
        for (int i = 0; i < N_SLAVES; i++) begin
            s_rdy  = (dsel_idx_q == SEL_W'(i)) ? HREADY_S[i]                   : s_rdy;
            s_resp = (dsel_idx_q == SEL_W'(i)) ? HRESP_S[i*RESP_W +: RESP_W]   : s_resp;
            s_data = (dsel_idx_q == SEL_W'(i)) ? HRDATA_S[i*DATA_W +: DATA_W]  : s_data;
        end
    end

    // Return-path FSM, watchdog and data-phase register next state.
    always_comb begin
        state_d    = state_q;
        rdy        = 1'b1;
        resp       = R_OK;
        data       = {DATA_W{1'b0}};
        to_ev      = 1'b0;
        wcnt_d     = {CW{1'b0}};
        dsel_def_d = dsel_def_q;
        dsel_idx_d = dsel_idx_q;
        dact_d     = dact_q;
        case (state_q)
            PASS: begin
                if (!dsel_def_q) begin
                    rdy  = s_rdy;
                    resp = s_resp;
                    data = s_data;
                    if (!s_rdy) begin
                        wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + CW'(1);
                        if ((TIMEOUT != 0) && (wcnt_q == WLIM)) begin
                            to_ev   = 1'b1;
                            state_d = ERR1;
                        end else begin
                            state_d = PASS;
                        end
                    end else begin
                        wcnt_d = {CW{1'b0}};
                    end
                end else if (dact_q) begin
                    rdy     = 1'b0;
                    resp    = R_ERR;
                    state_d = ERR1;
                end else begin
                    state_d = PASS;
                end
            end
            ERR1: begin
                rdy     = 1'b0;
                resp    = R_ERR;
                state_d = ERR2;
            end
            ERR2: begin
                rdy     = 1'b1;
                resp    = R_ERR;
                state_d = PASS;
            end
            default: begin
                state_d = PASS;
            end
        endcase
        // An active transfer to the default slave goes straight into the two-cycle error.
        if (rdy) begin
            dsel_def_d = a_def;
            dsel_idx_d = a_idx;
            dact_d     = HTRANS[1];
            if (a_def && HTRANS[1]) begin
                state_d = ERR1;
            end else begin
                state_d = state_d;
            end
        end else begin
            dact_d = dact_q;
        end
    end

    // Sticky timeout status: a timeout beats a simultaneous clear.
    always_comb begin
        to_flag_d  = to_flag_q;
        to_slave_d = to_slave_q;
        if (to_ev) begin
            to_flag_d  = 1'b1;
            to_slave_d = (!to_flag_q || to_clr) ? dsel_idx_q : to_slave_q;
        end else if (to_clr) begin
            to_flag_d  = 1'b0;
            to_slave_d = {SEL_W{1'b0}};
        end else begin
            to_flag_d  = to_flag_q;
        end
    end

    // State registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= PASS;
            dsel_def_q <= 1'b1;
            dsel_idx_q <= {SEL_W{1'b0}};
            dact_q     <= 1'b0;
            wcnt_q     <= {CW{1'b0}};
            to_flag_q  <= 1'b0;
            to_slave_q <= {SEL_W{1'b0}};
        end else begin
            state_q    <= state_d;
            dsel_def_q <= dsel_def_d;
            dsel_idx_q <= dsel_idx_d;
            dact_q     <= dact_d;
            wcnt_q     <= wcnt_d;
            to_flag_q  <= to_flag_d;
            to_slave_q <= to_slave_d;
        end
    end

    assign HRDATA   = data;
    assign HREADY   = rdy;
    assign HRESP    = resp;
    assign to_flag  = to_flag_q;
    assign to_slave = to_slave_q;

endmodule

// File: tb/tb_ahb_s2m_mux_gen.sv
// Directed, table-driven bench for ahb_s2m_mux_gen with TIMEOUT = 4.
module tb_ahb_s2m_mux_gen;

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;
    localparam logic [31:0] D2 = 32'h3333_0002;
    localparam logic [31:0] D3 = 32'hDEAD_BEEF;
    localparam logic [31:0] D4 = 32'h5555_0004;
    localparam logic [4:0]  A  = 5'b11111;
    localparam logic [1:0]  NS = 2'b10;
    localparam logic [1:0]  ID = 2'b00;

    logic         HCLK;
    logic         HRESET;
    logic [4:0]   HSEL;
    logic [1:0]   HTRANS;
    logic [159:0] HRDATA_S;
    logic [4:0]   HREADY_S;
    logic [9:0]   HRESP_S;
    logic         to_clr;
    logic [31:0]  HRDATA;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic         to_flag;
    logic [2:0]   to_slave;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  sel;
        logic [1:0]  trans;
        logic [4:0]  rdy;
        logic [9:0]  resp;
        logic        clr;
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [31:0] e_data;
        logic        e_flag;
        logic [2:0]  e_ts;
    } vec_t;

    vec_t vecs[$];

    ahb_s2m_mux_gen #(.N_SLAVES(5), .DATA_W(32), .RESP_W(2), .TIMEOUT(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS),
        .HRDATA_S(HRDATA_S), .HREADY_S(HREADY_S), .HRESP_S(HRESP_S),
        .to_clr(to_clr), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .to_flag(to_flag), .to_slave(to_slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic vec_t mk(input logic [4:0] sel, input logic [1:0] trans,
                                input logic [4:0] rdy, input logic [9:0] resp,
                                input logic clr, input logic e_rdy,
                                input logic [1:0] e_resp, input logic [31:0] e_data,
                                input logic e_flag, input logic [2:0] e_ts);
        vec_t v;
        v.sel = sel; v.trans = trans; v.rdy = rdy; v.resp = resp; v.clr = clr;
        v.e_rdy = e_rdy; v.e_resp = e_resp; v.e_data = e_data;
        v.e_flag = e_flag; v.e_ts = e_ts;
        return v;
    endfunction

    // Drive one cycle's inputs after the falling edge, then check the outputs.
    task automatic apply(input vec_t v, input logic rst, input string nm);
        @(negedge HCLK);
        HSEL = v.sel; HTRANS = v.trans; HREADY_S = v.rdy; HRESP_S = v.resp;
        to_clr = v.clr; HRESET = rst;
        #1;
        n_tests++;
        if ({HREADY, HRESP, HRDATA, to_flag, to_slave} !==
            {v.e_rdy, v.e_resp, v.e_data, v.e_flag, v.e_ts}) begin
            n_fail++;
            $display("FAIL %s: got rdy=%0b resp=%0d data=%h flag=%0b ts=%0d, want rdy=%0b resp=%0d data=%h flag=%0b ts=%0d",
                     nm, HREADY, HRESP, HRDATA, to_flag, to_slave,
                     v.e_rdy, v.e_resp, v.e_data, v.e_flag, v.e_ts);
        end
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 5'd0; HTRANS = ID; HREADY_S = A; HRESP_S = 10'd0;
        to_clr = 1'b0;
        HRDATA_S = {D4, D3, D2, D1, D0};
        repeat (2) @(posedge HCLK);

        // reset/idle, routing with waits, HSEL priority, default-slave error
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0));
        vecs.push_back(mk(5'b01000, NS, A,       10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, 5'b10111, 10'd0, 1'b0, 1'b0, 2'd0, D3,    1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, 5'b10111, 10'd0, 1'b0, 1'b0, 2'd0, D3,    1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b0, 1'b1, 2'd0, D3,    1'b0, 3'd0));
        vecs.push_back(mk(5'b01010, NS, A,       10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, NS, A,       10'd0, 1'b0, 1'b1, 2'd0, D1,    1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0, 3'd0));
        // ERR2 carries NONSEQ to slave 1
        vecs.push_back(mk(5'b00010, NS, A,       10'd0, 1'b0, 1'b1, 2'd1, 32'd0, 1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, 5'b11101, 10'd0, 1'b0, 1'b0, 2'd0, D1,    1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, 5'b11101, 10'd0, 1'b0, 1'b0, 2'd0, D1,    1'b0, 3'd0));
        vecs.push_back(mk(5'b00100, NS, A,       10'd0, 1'b0, 1'b1, 2'd0, D1,    1'b0, 3'd0));
        // slave 2 hangs: four wait cycles, then ERR1/ERR2; late slave response ignored
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(5'b00000, ID, 5'b11011, 10'd0, 1'b0, 1'b0, 2'd0, D2, 1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, A,       10'b0000010000, 1'b0, 1'b0, 2'd1, 32'd0, 1'b1, 3'd2));
        vecs.push_back(mk(5'b00001, NS, A,       10'b0000010000, 1'b0, 1'b1, 2'd1, 32'd0, 1'b1, 3'd2));
        // slave 0 hangs: flag stays, index stays 2
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(5'b00000, ID, 5'b11110, 10'd0, 1'b0, 1'b0, 2'd0, D0, 1'b1, 3'd2));
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b0, 1'b0, 2'd1, 32'd0, 1'b1, 3'd2));
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b0, 1'b1, 2'd1, 32'd0, 1'b1, 3'd2));
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b1, 1'b1, 2'd0, 32'd0, 1'b1, 3'd2));
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0));
        // slave 4 gives its own two-cycle ERROR, passed through
        vecs.push_back(mk(5'b10000, NS, A,       10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, 5'b01111, 10'b0100000000, 1'b0, 1'b0, 2'd1, D4, 1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, A,       10'b0100000000, 1'b0, 1'b1, 2'd1, D4, 1'b0, 3'd0));
        vecs.push_back(mk(5'b00000, ID, A,       10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0));

        foreach (vecs[i]) apply(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Timeout on slave 3 sets the flag; a second timeout coinciding with to_clr recaptures.
        apply(mk(5'b01000, NS, A, 10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0), 1'b0, "clr_addr3");
        for (int k = 0; k < 4; k++)
            apply(mk(5'b00000, ID, 5'b10111, 10'd0, 1'b0, 1'b0, 2'd0, D3, 1'b0, 3'd0), 1'b0,
                  $sformatf("clr_wait3_%0d", k));
        apply(mk(5'b00000, ID, A, 10'd0, 1'b0, 1'b0, 2'd1, 32'd0, 1'b1, 3'd3), 1'b0, "clr_err1_s3");
        apply(mk(5'b00010, NS, A, 10'd0, 1'b0, 1'b1, 2'd1, 32'd0, 1'b1, 3'd3), 1'b0, "clr_err2_s3");
        for (int k = 0; k < 3; k++)
            apply(mk(5'b00000, ID, 5'b11101, 10'd0, 1'b0, 1'b0, 2'd0, D1, 1'b1, 3'd3), 1'b0,
                  $sformatf("clr_wait1_%0d", k));
        apply(mk(5'b00000, ID, 5'b11101, 10'd0, 1'b1, 1'b0, 2'd0, D1, 1'b1, 3'd3), 1'b0, "clr_same_cycle");
        apply(mk(5'b00000, ID, A, 10'd0, 1'b0, 1'b0, 2'd1, 32'd0, 1'b1, 3'd1), 1'b0, "clr_err1_s1");
        // ERR2 carries a NONSEQ to the default slave, so ERR1 follows
        apply(mk(5'b00000, NS, A, 10'd0, 1'b0, 1'b1, 2'd1, 32'd0, 1'b1, 3'd1), 1'b0, "rst_err2");
        // Reset asserted during ERR1: no ERR2 afterwards
        apply(mk(5'b00000, ID, A, 10'd0, 1'b0, 1'b0, 2'd1, 32'd0, 1'b1, 3'd1), 1'b1, "rst_in_err1");
        apply(mk(5'b00000, ID, A, 10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0), 1'b0, "rst_after");
        apply(mk(5'b00000, ID, A, 10'd0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 3'd0), 1'b0, "rst_no_err2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
